// File: rtl/mig_ui_responder.sv
// Memory-controller side of the MIG UI (app_*) protocol: stores two-beat bursts in a small array,
// returns read bursts in order after a fixed latency, and injects calibration delay and back-pressure.
module mig_ui_responder #(
    parameter int unsigned ADDR_WIDTH     = 27,
    parameter int unsigned APP_DATA_WIDTH = 256,
    parameter int unsigned MEM_LOG2       = 6,
    parameter int unsigned RD_LATENCY     = 8,
    parameter int unsigned CALIB_CYCLES   = 100,
    parameter int unsigned BUSY_EVERY     = 16,
    parameter int unsigned BUSY_CYCLES    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      init_calib_complete,
    input  logic                      app_en,
    input  logic [2:0]                app_cmd,
    input  logic [ADDR_WIDTH-1:0]     app_addr,
    output logic                      app_rdy,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_end,
    input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic                      app_wdf_rdy,
    output logic                      app_rd_data_valid,
    output logic                      app_rd_data_end,
    output logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      error
);

    localparam int unsigned BEATS   = 2 ** (MEM_LOG2 + 1);
    localparam int unsigned CALIB_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int unsigned ACC_W   = (BUSY_EVERY > 1) ? $clog2(BUSY_EVERY) : 1;
    localparam int unsigned BUSY_W  = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWr1, StRd1} eng_state_e;

    // Calibration
    logic [CALIB_W-1:0] calib_cnt_q;
    logic               calib_q;

    // Back-pressure
    logic [ACC_W-1:0]   acc_cnt_q;
    logic [BUSY_W-1:0]  busy_cnt_q;

    // Command FIFO
    logic                cmd_rd_q   [4];
    logic [MEM_LOG2-1:0] cmd_slot_q [4];
    logic [1:0]          cmd_wptr_q, cmd_rptr_q;
    logic [2:0]          cmd_count_q;
    logic                cmd_accept, cmd_legal, cmd_push, cmd_pop;
    logic                head_rd;
    logic [MEM_LOG2-1:0] head_slot;

    // Write-data FIFO
    logic [APP_DATA_WIDTH-1:0] wdf_data_q [4];
    logic                      wdf_end_q  [4];
    logic [1:0]                wdf_wptr_q, wdf_rptr_q;
    logic [2:0]                wdf_count_q;
    logic                      wdf_push, wdf_pop, wdf_head_end;

    // Engine
    eng_state_e        state_q, state_d;
    logic              mem_we;
    logic [MEM_LOG2:0] mem_waddr;
    logic              rd_push, rd_end;
    logic [MEM_LOG2:0] rd_addr;
    logic              end_err;

    // Storage and read pipeline
    logic [APP_DATA_WIDTH-1:0] mem         [BEATS];
    logic [APP_DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]     pipe_vld_q, pipe_end_q;

    logic error_q;

    // Only the slot field of the byte address is decoded.
    logic unused_addr;
    assign unused_addr = ^{app_addr[ADDR_WIDTH-1:6+MEM_LOG2], app_addr[5:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            calib_cnt_q <= '0;
            calib_q     <= (CALIB_CYCLES == 0);
        end else if (!calib_q) begin
            calib_cnt_q <= calib_cnt_q + CALIB_W'(1);
            if (calib_cnt_q == CALIB_W'(CALIB_CYCLES - 1)) begin
                calib_q <= 1'b1;
            end
        end
    end

    assign cmd_accept = app_en && app_rdy;
    assign cmd_legal  = (app_cmd[2:1] == 2'b00);
    assign cmd_push   = cmd_accept && cmd_legal;
    assign wdf_push   = app_wdf_wren && app_wdf_rdy;

    assign app_rdy     = calib_q && (cmd_count_q != 3'd4) && (busy_cnt_q == '0);
    assign app_wdf_rdy = calib_q && (wdf_count_q != 3'd4);

    // No command is accepted while busy, so reload and decrement never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (busy_cnt_q != '0) begin
                busy_cnt_q <= busy_cnt_q - BUSY_W'(1);
            end
            if (cmd_accept && (BUSY_EVERY != 0)) begin
                if (acc_cnt_q == ACC_W'(BUSY_EVERY - 1)) begin
                    acc_cnt_q  <= '0;
                    busy_cnt_q <= BUSY_W'(BUSY_CYCLES);
                end else begin
                    acc_cnt_q <= acc_cnt_q + ACC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            cmd_count_q <= '0;
        end else begin
            if (cmd_push) begin
                cmd_rd_q[cmd_wptr_q]   <= app_cmd[0];
                cmd_slot_q[cmd_wptr_q] <= app_addr[6 +: MEM_LOG2];
                cmd_wptr_q             <= cmd_wptr_q + 2'd1;
            end
            if (cmd_pop) begin
                cmd_rptr_q <= cmd_rptr_q + 2'd1;
            end
            cmd_count_q <= cmd_count_q + {2'b00, cmd_push} - {2'b00, cmd_pop};
        end
    end

    assign head_rd   = cmd_rd_q[cmd_rptr_q];
    assign head_slot = cmd_slot_q[cmd_rptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wdf_wptr_q  <= '0;
            wdf_rptr_q  <= '0;
            wdf_count_q <= '0;
        end else begin
            if (wdf_push) begin
                wdf_data_q[wdf_wptr_q] <= app_wdf_data;
                wdf_end_q[wdf_wptr_q]  <= app_wdf_end;
                wdf_wptr_q             <= wdf_wptr_q + 2'd1;
            end
            if (wdf_pop) begin
                wdf_rptr_q <= wdf_rptr_q + 2'd1;
            end
            wdf_count_q <= wdf_count_q + {2'b00, wdf_push} - {2'b00, wdf_pop};
        end
    end

    assign wdf_head_end = wdf_end_q[wdf_rptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // One beat per cycle: a burst occupies the engine for two cycles.
    always_comb begin
        state_d   = state_q;
        cmd_pop   = 1'b0;
        wdf_pop   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = {head_slot, 1'b0};
        rd_push   = 1'b0;
        rd_end    = 1'b0;
        rd_addr   = {head_slot, 1'b0};
        end_err   = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_count_q != 3'd0) begin
                    if (head_rd) begin
                        rd_push = 1'b1;
                        state_d = StRd1;
                    end else if (wdf_count_q >= 3'd2) begin
                        mem_we  = 1'b1;
                        wdf_pop = 1'b1;
                        end_err = wdf_head_end;
                        state_d = StWr1;
                    end
                end
            end
            StWr1: begin
                mem_we    = 1'b1;
                mem_waddr = {head_slot, 1'b1};
                wdf_pop   = 1'b1;
                end_err   = !wdf_head_end;
                cmd_pop   = 1'b1;
                state_d   = StIdle;
            end
            StRd1: begin
                rd_push = 1'b1;
                rd_end  = 1'b1;
                rd_addr = {head_slot, 1'b1};
                cmd_pop = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The array is read at push time so a later write to the same slot cannot leak into the beat.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= wdf_data_q[wdf_rptr_q];
        end
        if (rd_push) begin
            pipe_data_q[0] <= mem[rd_addr];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            if (pipe_vld_q[i-1]) begin
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
        if (reset) begin
            pipe_data_q[RD_LATENCY-1] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q <= '0;
            pipe_end_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_push;
            pipe_end_q[0] <= rd_end;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_end_q[i] <= pipe_end_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if ((cmd_accept && !cmd_legal) || end_err) begin
            error_q <= 1'b1;
        end
    end

    assign init_calib_complete = calib_q;
    assign app_rd_data_valid   = pipe_vld_q[RD_LATENCY-1];
    assign app_rd_data_end     = pipe_vld_q[RD_LATENCY-1] && pipe_end_q[RD_LATENCY-1];
    assign app_rd_data         = pipe_data_q[RD_LATENCY-1];
    assign error               = error_q;

endmodule
